// File: rtl/reg_write_bank.sv
// Register-file write side: a 32-entry bank with a tree-structured 5:32
// write decoder, XZR hard-wired to zero, and write status and debug outputs.

// One storage register; loads d when its decoded write enable is set.
module reg_write_bank_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset, otherwise load on an enabled write.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (we)
            q <= d;
    end

endmodule

module reg_write_bank #(
    parameter int WIDTH = 64,
    parameter int NREG  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [WIDTH-1:0]      WriteData,
    output logic [NREG*WIDTH-1:0] regs_out,
    output logic [31:0]           wr_onehot,
    output logic                  write_done,
    output logic [15:0]           write_count
);

    logic                            accept;
    logic [3:0]                      grp;
    logic [31:0]                     dec;
    logic [NREG-1:0][WIDTH-1:0]      regs;

    // A reset in the same cycle wins over the write, so it never reaches the decoder.
    assign accept = RegWrite & ~reset;

    // 2:4 predecode on the upper address bits selects one 3:8 group.
    always_comb begin
        grp = '0;
        if (accept)
            grp[WriteRegister[4:3]] = 1'b1;
    end

    // Four 3:8 decoders on the low bits, each gated by its predecode line.
    for (genvar g = 0; g < 4; g++) begin : g_grp
        for (genvar i = 0; i < 8; i++) begin : g_dec
            assign dec[g*8+i] = grp[g] & (WriteRegister[2:0] == 3'(i));
        end
    end

    // Registers 0..30 hold state; register 31 (XZR) has no storage and reads zero.
    for (genvar k = 0; k < NREG; k++) begin : g_reg
        if (k == NREG - 1) begin : g_xzr
            assign regs[k] = '0;
        end else begin : g_slot
            reg_write_bank_slot #(.WIDTH(WIDTH)) u_slot (
                .clk   (clk),
                .reset (reset),
                .we    (dec[k]),
                .d     (WriteData),
                .q     (regs[k])
            );
        end
    end

    // Packed array layout already puts register k at [k*WIDTH +: WIDTH].
    assign regs_out = regs;

    // Status: last-write one-hot (held when idle), done pulse and saturating count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_onehot   <= '0;
            write_done  <= 1'b0;
            write_count <= '0;
        end else begin
            write_done <= accept;
            if (accept) begin
                wr_onehot <= dec;
                if (write_count != 16'hFFFF)
                    write_count <= write_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_bank.sv
// Directed bench for reg_write_bank: reset state, sequential writes, XZR,
// same-address overwrite, idle hold, reset priority and count saturation.
module tb_reg_write_bank;

    localparam int WIDTH = 64;
    localparam int NREG  = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  RegWrite;
    logic [4:0]            WriteRegister;
    logic [WIDTH-1:0]      WriteData;
    logic [NREG*WIDTH-1:0] regs_out;
    logic [31:0]           wr_onehot;
    logic                  write_done;
    logic [15:0]           write_count;

    int nvec = 0;
    int nerr = 0;
    logic [WIDTH-1:0] exp_reg [NREG];

    reg_write_bank #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .regs_out      (regs_out),
        .wr_onehot     (wr_onehot),
        .write_done    (write_done),
        .write_count   (write_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] field(input int k);
        return regs_out[k*WIDTH +: WIDTH];
    endfunction

    // advance one clock and sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input logic [WIDTH-1:0] d);
        RegWrite      = 1'b1;
        WriteRegister = 5'(r);
        WriteData     = d;
        step();
    endtask

    task automatic clear_model();
        for (int k = 0; k < NREG; k++) exp_reg[k] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        step(); step();
        reset = 1'b0;
        step();
        clear_model();
        for (int k = 0; k < NREG; k++) begin
            nvec++;
            if (field(k) !== 64'h0) begin
                nerr++; $display("FAIL reset_reg%0d: got %h want 0", k, field(k));
            end
        end
        nvec++; if (write_count !== 16'h0) begin nerr++; $display("FAIL reset_count: got %h want 0", write_count); end
        nvec++; if (write_done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", write_done); end
        nvec++; if (wr_onehot !== 32'h0) begin nerr++; $display("FAIL reset_onehot: got %h want 0", wr_onehot); end
    endtask

    task automatic test_sequential();
        wr(0, 64'h1);
        nvec++; if (field(0) !== 64'h1) begin nerr++; $display("FAIL seq_r0: got %h want 1", field(0)); end
        nvec++; if (field(1) !== 64'h0) begin nerr++; $display("FAIL seq_r1_early: got %h want 0", field(1)); end
        nvec++; if (wr_onehot !== 32'h1) begin nerr++; $display("FAIL seq_oh0: got %h want 1", wr_onehot); end
        nvec++; if (write_done !== 1'b1) begin nerr++; $display("FAIL seq_done0: got %b want 1", write_done); end
        wr(1, 64'h2);
        nvec++; if (field(1) !== 64'h2) begin nerr++; $display("FAIL seq_r1: got %h want 2", field(1)); end
        nvec++; if (wr_onehot !== 32'h2) begin nerr++; $display("FAIL seq_oh1: got %h want 2", wr_onehot); end
        nvec++; if (write_done !== 1'b1) begin nerr++; $display("FAIL seq_done1: got %b want 1", write_done); end
        wr(2, 64'h4);
        nvec++; if (field(2) !== 64'h4) begin nerr++; $display("FAIL seq_r2: got %h want 4", field(2)); end
        nvec++; if (wr_onehot !== 32'h4) begin nerr++; $display("FAIL seq_oh2: got %h want 4", wr_onehot); end
        nvec++; if (write_done !== 1'b1) begin nerr++; $display("FAIL seq_done2: got %b want 1", write_done); end
        RegWrite = 1'b0;
        step();
        exp_reg[0] = 64'h1; exp_reg[1] = 64'h2; exp_reg[2] = 64'h4;
        nvec++; if (write_done !== 1'b0) begin nerr++; $display("FAIL seq_done_idle: got %b want 0", write_done); end
        nvec++; if (write_count !== 16'd3) begin nerr++; $display("FAIL seq_count: got %0d want 3", write_count); end
        nvec++; if (wr_onehot !== 32'h4) begin nerr++; $display("FAIL seq_oh_hold: got %h want 4", wr_onehot); end
    endtask

    task automatic test_xzr();
        wr(31, 64'hFFFF_FFFF_FFFF_FFFF);
        RegWrite = 1'b0;
        nvec++; if (field(31) !== 64'h0) begin nerr++; $display("FAIL xzr_r31: got %h want 0", field(31)); end
        nvec++; if (wr_onehot !== 32'h8000_0000) begin nerr++; $display("FAIL xzr_oh: got %h want 80000000", wr_onehot); end
        nvec++; if (write_count !== 16'd4) begin nerr++; $display("FAIL xzr_count: got %0d want 4", write_count); end
        nvec++; if (write_done !== 1'b1) begin nerr++; $display("FAIL xzr_done: got %b want 1", write_done); end
        for (int k = 0; k < NREG; k++) begin
            nvec++;
            if (field(k) !== exp_reg[k]) begin
                nerr++; $display("FAIL xzr_keep_r%0d: got %h want %h", k, field(k), exp_reg[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        wr(5, 64'hA);
        nvec++; if (field(5) !== 64'hA) begin nerr++; $display("FAIL b2b_first: got %h want a", field(5)); end
        wr(5, 64'hB);
        RegWrite = 1'b0;
        exp_reg[5] = 64'hB;
        nvec++; if (field(5) !== 64'hB) begin nerr++; $display("FAIL b2b_r5: got %h want b", field(5)); end
        nvec++; if (field(4) !== 64'h0) begin nerr++; $display("FAIL b2b_r4: got %h want 0", field(4)); end
        nvec++; if (field(6) !== 64'h0) begin nerr++; $display("FAIL b2b_r6: got %h want 0", field(6)); end
        nvec++; if (wr_onehot !== 32'h20) begin nerr++; $display("FAIL b2b_oh: got %h want 20", wr_onehot); end
        nvec++; if (write_count !== 16'd6) begin nerr++; $display("FAIL b2b_count: got %0d want 6", write_count); end
    endtask

    task automatic test_ignore_idle();
        RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'hDEAD_BEEF;
        step(); step();
        nvec++; if (field(3) !== 64'h0) begin nerr++; $display("FAIL idle_r3: got %h want 0", field(3)); end
        nvec++; if (wr_onehot !== 32'h20) begin nerr++; $display("FAIL idle_oh: got %h want 20", wr_onehot); end
        nvec++; if (write_done !== 1'b0) begin nerr++; $display("FAIL idle_done: got %b want 0", write_done); end
        nvec++; if (write_count !== 16'd6) begin nerr++; $display("FAIL idle_count: got %0d want 6", write_count); end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        wr(7, 64'h77);
        reset = 1'b0; RegWrite = 1'b0;
        clear_model();
        for (int k = 0; k < NREG; k++) begin
            nvec++;
            if (field(k) !== 64'h0) begin
                nerr++; $display("FAIL rstpri_r%0d: got %h want 0", k, field(k));
            end
        end
        nvec++; if (write_count !== 16'd0) begin nerr++; $display("FAIL rstpri_count: got %0d want 0", write_count); end
        nvec++; if (write_done !== 1'b0) begin nerr++; $display("FAIL rstpri_done: got %b want 0", write_done); end
        nvec++; if (wr_onehot !== 32'h0) begin nerr++; $display("FAIL rstpri_oh: got %h want 0", wr_onehot); end
        wr(7, 64'h99);
        RegWrite = 1'b0;
        nvec++; if (field(7) !== 64'h99) begin nerr++; $display("FAIL rstpri_after: got %h want 99", field(7)); end
        nvec++; if (write_count !== 16'd1) begin nerr++; $display("FAIL rstpri_after_count: got %0d want 1", write_count); end
        nvec++; if (wr_onehot !== 32'h80) begin nerr++; $display("FAIL rstpri_after_oh: got %h want 80", wr_onehot); end
    endtask

    task automatic test_saturate();
        reset = 1'b1; RegWrite = 1'b0;
        step();
        reset = 1'b0;
        RegWrite = 1'b1; WriteRegister = 5'd8;
        for (int i = 0; i < 65534; i++) begin
            WriteData = 64'(i);
            step();
        end
        nvec++; if (write_count !== 16'hFFFE) begin nerr++; $display("FAIL sat_fffe: got %h want fffe", write_count); end
        WriteData = 64'h1234; step();
        nvec++; if (write_count !== 16'hFFFF) begin nerr++; $display("FAIL sat_ffff: got %h want ffff", write_count); end
        for (int i = 0; i < 5; i++) begin
            WriteData = 64'h5000 + 64'(i);
            step();
        end
        RegWrite = 1'b0;
        nvec++; if (write_count !== 16'hFFFF) begin nerr++; $display("FAIL sat_hold: got %h want ffff", write_count); end
        nvec++; if (field(8) !== 64'h5004) begin nerr++; $display("FAIL sat_r8: got %h want 5004", field(8)); end
        nvec++; if (write_done !== 1'b1) begin nerr++; $display("FAIL sat_done: got %b want 1", write_done); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_xzr();
        test_back_to_back();
        test_ignore_idle();
        test_reset_priority();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
